// File: rtl/dimm_multibank_model.sv
// Multi-bank DDR4 DIMM behavioural model: decodes the command bus, tracks open rows, stores/returns bursts.
// Latency: write beats land on edges CWL..CWL+n-1 after WR; read beat i is visible after edge CL-1+i.
// Backpressure: none; only one column command in flight, extra RD/WR are dropped with err_overlap.
//
// Ports:
//   CK_t, reset_n                               clock, synchronous active-low reset
//   cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14 command bus
//   bg_addr, ba_addr, A12_BC_n, A10_AP, addr    bank / burst-length / auto-precharge / row-or-column address
//   dq_in                                       write beat, one per CK_t edge
//   rd_dq, rd_vld                               registered read beat and its valid
//   bank_open, burst_busy                       per-bank open flags, column command in flight
//   err_closed, err_act_open, err_trcd,
//   err_overlap, err_sticky                     one-cycle protocol error pulses and their sticky OR
module dimm_multibank_model #(
  parameter int BG_BITS  = 1,
  parameter int BA_BITS  = 2,
  parameter int ROW_BITS = 6,
  parameter int COL_BITS = 6,
  parameter int DQ_W     = 8,
  parameter int CL       = 4,
  parameter int CWL      = 3,
  parameter int T_RCD    = 3
) (
  input  logic                                              CK_t,
  input  logic                                              reset_n,
  input  logic                                              cs_n,
  input  logic                                              act_n,
  input  logic                                              RAS_n_A16,
  input  logic                                              CAS_n_A15,
  input  logic                                              WE_n_A14,
  input  logic [BG_BITS-1:0]                                bg_addr,
  input  logic [BA_BITS-1:0]                                ba_addr,
  input  logic                                              A12_BC_n,
  input  logic                                              A10_AP,
  input  logic [((ROW_BITS > COL_BITS) ? ROW_BITS : COL_BITS)-1:0] addr,
  input  logic [DQ_W-1:0]                                   dq_in,
  output logic [DQ_W-1:0]                                   rd_dq,
  output logic                                              rd_vld,
  output logic [(2**(BG_BITS+BA_BITS))-1:0]                 bank_open,
  output logic                                              burst_busy,
  output logic                                              err_closed,
  output logic                                              err_act_open,
  output logic                                              err_trcd,
  output logic                                              err_overlap,
  output logic                                              err_sticky
);

  localparam int BANK_W = BG_BITS + BA_BITS;
  localparam int NB     = 2**BANK_W;
  localparam int IDX_W  = BANK_W + ROW_BITS + COL_BITS;
  localparam int MEM_D  = 2**IDX_W;
  localparam int T_W    = $clog2(CL + CWL + 16);
  localparam int AGE_W  = $clog2(T_RCD + 1);

  localparam logic [T_W-1:0]   WR_FIRST = T_W'(CWL);
  localparam logic [T_W-1:0]   RD_FIRST = T_W'(CL - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(T_RCD);
  localparam logic [AGE_W:0]   TRCD_X   = (AGE_W+1)'(T_RCD);

  // Command decode
  logic [4:0]          cmd;
  logic                is_act, is_wr, is_rd, is_pre, is_col;
  logic [BANK_W-1:0]   cmd_bank;
  logic [ROW_BITS-1:0] cmd_row;
  logic [COL_BITS-1:0] cmd_col;

  assign cmd      = {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14};
  assign is_act   = !cs_n && !act_n;
  assign is_wr    = (cmd == 5'b01100);
  assign is_rd    = (cmd == 5'b01101);
  assign is_pre   = (cmd == 5'b01010);
  assign is_col   = is_wr || is_rd;
  assign cmd_bank = {bg_addr, ba_addr};
  assign cmd_row  = addr[ROW_BITS-1:0];
  assign cmd_col  = addr[COL_BITS-1:0];

  // Per-bank state and the array itself
  logic [ROW_BITS-1:0] open_row [NB];
  logic [AGE_W-1:0]    age      [NB];
  logic [DQ_W-1:0]     mem      [MEM_D];

  // Latched column command; t equals the number of edges since it was accepted
  logic                b_wr, b_bl8, b_ap;
  logic [BANK_W-1:0]   b_bank;
  logic [ROW_BITS-1:0] b_row;
  logic [COL_BITS-1:0] b_col;
  logic [T_W-1:0]      t;

  // Acceptance checks, all evaluated against the state before this edge
  logic e_closed, e_act_open, e_trcd, e_overlap, accept;

  assign e_act_open = is_act && bank_open[cmd_bank];
  assign e_closed   = is_col && !bank_open[cmd_bank];
  // age holds (edges since ACT) - 1, so +1 gives the ACT-to-command distance
  assign e_trcd     = is_col && bank_open[cmd_bank] && (({1'b0, age[cmd_bank]} + 1'b1) < TRCD_X);
  assign e_overlap  = is_col && bank_open[cmd_bank] && burst_busy;
  assign accept     = is_col && bank_open[cmd_bank] && !burst_busy;

  // Beat scheduling
  logic [T_W-1:0]      b_len, first_t, last_t;
  logic                beat_now, beat_last;
  logic [2:0]          beat, lo8;
  logic [1:0]          lo4;
  logic [COL_BITS-1:0] beat_col;
  logic [IDX_W-1:0]    mem_idx;

  assign b_len     = b_bl8 ? T_W'(8) : T_W'(4);
  assign first_t   = b_wr ? WR_FIRST : RD_FIRST;
  assign last_t    = first_t + b_len - 1'b1;
  assign beat_now  = burst_busy && (t >= first_t) && (t <= last_t);
  assign beat_last = burst_busy && (t == last_t);
  assign beat      = t[2:0] - first_t[2:0];
  assign lo8       = b_col[2:0] + beat;
  assign lo4       = b_col[1:0] + beat[1:0];

  // Column wraps inside the aligned 8- or 4-beat block
  always_comb begin
    beat_col = b_col;
    if (b_bl8) beat_col[2:0] = lo8;
    else       beat_col[1:0] = lo4;
  end

  assign mem_idx = {b_bank, b_row, beat_col};

  // Array is never cleared by reset; a reset edge also suppresses the write
  always_ff @(posedge CK_t) begin
    if (reset_n && beat_now && b_wr) mem[mem_idx] <= dq_in;
  end

  always_ff @(posedge CK_t) begin
    if (!reset_n) begin
      bank_open    <= '0;
      rd_dq        <= '0;
      rd_vld       <= 1'b0;
      burst_busy   <= 1'b0;
      err_closed   <= 1'b0;
      err_act_open <= 1'b0;
      err_trcd     <= 1'b0;
      err_overlap  <= 1'b0;
      err_sticky   <= 1'b0;
      b_wr         <= 1'b0;
      b_bl8        <= 1'b0;
      b_ap         <= 1'b0;
      b_bank       <= '0;
      b_row        <= '0;
      b_col        <= '0;
      t            <= '0;
      for (int i = 0; i < NB; i++) begin
        age[i]      <= '0;
        open_row[i] <= '0;
      end
    end else begin
      err_closed   <= e_closed;
      err_act_open <= e_act_open;
      err_trcd     <= e_trcd;
      err_overlap  <= e_overlap;
      err_sticky   <= err_sticky | e_closed | e_act_open | e_trcd | e_overlap;

      rd_vld <= 1'b0;
      rd_dq  <= '0;

      for (int i = 0; i < NB; i++) begin
        if (age[i] != AGE_MAX) age[i] <= age[i] + 1'b1;
      end

      if (burst_busy) begin
        t <= t + 1'b1;
        if (beat_now && !b_wr) begin
          rd_vld <= 1'b1;
          rd_dq  <= mem[mem_idx];
        end
        if (beat_last) begin
          burst_busy <= 1'b0;
          if (b_ap) bank_open[b_bank] <= 1'b0;
        end
      end

      // Commands are applied after burst completion so they win on the same bank
      if (is_act && !bank_open[cmd_bank]) begin
        bank_open[cmd_bank] <= 1'b1;
        open_row[cmd_bank]  <= cmd_row;
        age[cmd_bank]       <= '0;
      end else if (is_pre) begin
        if (A10_AP) bank_open <= '0;
        else        bank_open[cmd_bank] <= 1'b0;
      end else if (accept) begin
        burst_busy <= 1'b1;
        t          <= T_W'(1);
        b_wr       <= is_wr;
        b_bl8      <= A12_BC_n;
        b_ap       <= A10_AP;
        b_bank     <= cmd_bank;
        b_row      <= open_row[cmd_bank];
        b_col      <= cmd_col;
      end
    end
  end

endmodule

// File: tb/tb_dimm_multibank_model.sv
// Bench for dimm_multibank_model: directed protocol scenarios followed by random command traffic.
// Every cycle the outputs are compared with an edge-numbered reference model of the DIMM.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_dimm_multibank_model;

  localparam int CL    = 4;
  localparam int CWL   = 3;
  localparam int T_RCD = 3;

  logic       CK_t = 1'b0;
  logic       reset_n;
  logic       cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
  logic [0:0] bg_addr;
  logic [1:0] ba_addr;
  logic       A12_BC_n, A10_AP;
  logic [5:0] addr;
  logic [7:0] dq_in;
  logic [7:0] rd_dq;
  logic       rd_vld;
  logic [7:0] bank_open;
  logic       burst_busy;
  logic       err_closed, err_act_open, err_trcd, err_overlap, err_sticky;

  int checks = 0;
  int errors = 0;

  dimm_multibank_model #(
    .BG_BITS(1), .BA_BITS(2), .ROW_BITS(6), .COL_BITS(6),
    .DQ_W(8), .CL(CL), .CWL(CWL), .T_RCD(T_RCD)
  ) dut (
    .CK_t(CK_t), .reset_n(reset_n),
    .cs_n(cs_n), .act_n(act_n), .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14),
    .bg_addr(bg_addr), .ba_addr(ba_addr), .A12_BC_n(A12_BC_n), .A10_AP(A10_AP),
    .addr(addr), .dq_in(dq_in), .rd_dq(rd_dq), .rd_vld(rd_vld),
    .bank_open(bank_open), .burst_busy(burst_busy),
    .err_closed(err_closed), .err_act_open(err_act_open), .err_trcd(err_trcd),
    .err_overlap(err_overlap), .err_sticky(err_sticky)
  );

  always #5 CK_t = ~CK_t;

  // Reference model: edge numbers, per-bank flags and a sparse memory
  logic [7:0] m_mem [int];
  bit   [7:0] m_open;
  int         m_row [8];
  int         m_act [8];
  int         e = 0;
  bit         m_busy, mb_wr, mb_bl8, mb_ap;
  int         mb_bank, mb_row, mb_col, mb_start;
  bit         x_vld, x_known, x_sticky;
  logic [7:0] x_dq;
  bit   [3:0] x_err;   // {closed, act_open, trcd, overlap}
  logic [7:0] rd_log [$];
  logic [7:0] bc_exp [8];
  int         rnd_r, rnd_b;

  function automatic int mem_addr(int bank, int row, int col, bit bl8, int i);
    int c;
    if (bl8) c = (col / 8) * 8 + (col + i) % 8;
    else     c = (col / 4) * 4 + (col + i) % 4;
    return bank * 4096 + row * 64 + c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit [7:0] o_open, n_open;
    bit       o_busy, end_burst, c_act, c_wr, c_rd, c_pre;
    int       b, k, i, n, last, a;
    e++;
    if (!reset_n) begin
      m_open = '0; m_busy = 0; x_vld = 0; x_dq = '0; x_known = 1; x_err = '0; x_sticky = 0;
      return;
    end
    o_open = m_open; o_busy = m_busy; n_open = m_open;
    x_vld = 0; x_dq = '0; x_known = 1; x_err = '0; end_burst = 0;
    if (m_busy) begin
      k = e - mb_start;
      n = mb_bl8 ? 8 : 4;
      if (mb_wr) begin
        i = k - CWL;
        last = CWL + n - 1;
        if (i >= 0 && i < n) m_mem[mem_addr(mb_bank, mb_row, mb_col, mb_bl8, i)] = dq_in;
      end else begin
        i = k - (CL - 1);
        last = CL - 2 + n;
        if (i >= 0 && i < n) begin
          x_vld = 1;
          a = mem_addr(mb_bank, mb_row, mb_col, mb_bl8, i);
          if (m_mem.exists(a)) x_dq = m_mem[a];
          else x_known = 0;
        end
      end
      if (k == last) end_burst = 1;
    end
    if (end_burst) begin
      m_busy = 0;
      if (mb_ap) n_open[mb_bank] = 0;
    end
    c_act = !cs_n && !act_n;
    c_wr  = !cs_n && act_n && ({RAS_n_A16, CAS_n_A15, WE_n_A14} == 3'b100);
    c_rd  = !cs_n && act_n && ({RAS_n_A16, CAS_n_A15, WE_n_A14} == 3'b101);
    c_pre = !cs_n && act_n && ({RAS_n_A16, CAS_n_A15, WE_n_A14} == 3'b010);
    b = int'(bg_addr) * 4 + int'(ba_addr);
    if (c_act) begin
      if (o_open[b]) x_err[2] = 1;
      else begin
        n_open[b] = 1; m_row[b] = int'(addr); m_act[b] = e;
      end
    end else if (c_pre) begin
      if (A10_AP) n_open = '0;
      else n_open[b] = 0;
    end else if (c_wr || c_rd) begin
      if (!o_open[b]) x_err[3] = 1;
      else begin
        if (e - m_act[b] < T_RCD) x_err[1] = 1;
        if (o_busy) x_err[0] = 1;
        else begin
          m_busy = 1; mb_wr = c_wr; mb_bl8 = A12_BC_n; mb_ap = A10_AP;
          mb_bank = b; mb_row = m_row[b]; mb_col = int'(addr); mb_start = e;
        end
      end
    end
    m_open = n_open;
    if (x_err != 0) x_sticky = 1;
  endtask

  task automatic compare_all();
    chk("bank_open", 32'(bank_open), 32'(m_open));
    chk("burst_busy", 32'(burst_busy), 32'(m_busy));
    chk("rd_vld", 32'(rd_vld), 32'(x_vld));
    if (!x_vld || x_known) chk("rd_dq", 32'(rd_dq), 32'(x_dq));
    chk("err_vec", 32'({err_closed, err_act_open, err_trcd, err_overlap}), 32'(x_err));
    chk("err_sticky", 32'(err_sticky), 32'(x_sticky));
  endtask

  task automatic step();
    @(posedge CK_t);
    model_edge();
    @(negedge CK_t);
    compare_all();
    if (rd_vld) rd_log.push_back(rd_dq);
  endtask

  task automatic set_nop();
    cs_n = 1; act_n = 1; RAS_n_A16 = 1; CAS_n_A15 = 1; WE_n_A14 = 1;
    bg_addr = '0; ba_addr = '0; A12_BC_n = 1; A10_AP = 0; addr = '0;
  endtask

  task automatic set_bank(input int b);
    bg_addr = 1'(b / 4);
    ba_addr = 2'(b % 4);
  endtask

  task automatic set_act(input int b, input int row);
    cs_n = 0; act_n = 0; RAS_n_A16 = 1; CAS_n_A15 = 1; WE_n_A14 = 1;
    set_bank(b); A12_BC_n = 1; A10_AP = 0; addr = 6'(row);
  endtask

  task automatic set_col(input bit wr, input int b, input int col, input bit bl8, input bit ap);
    cs_n = 0; act_n = 1; RAS_n_A16 = 1; CAS_n_A15 = 0; WE_n_A14 = !wr;
    set_bank(b); A12_BC_n = bl8; A10_AP = ap; addr = 6'(col);
  endtask

  task automatic set_pre(input int b, input bit all);
    cs_n = 0; act_n = 1; RAS_n_A16 = 0; CAS_n_A15 = 1; WE_n_A14 = 0;
    set_bank(b); A12_BC_n = 1; A10_AP = all; addr = '0;
  endtask

  task automatic open_bank(input int b, input int row);
    set_act(b, row); step();
    set_nop(); step(); step();
  endtask

  task automatic wr_burst(input int b, input int col, input bit bl8, input bit ap, input int base);
    int n;
    n = bl8 ? 8 : 4;
    set_col(1, b, col, bl8, ap); dq_in = 8'($urandom); step();
    set_nop();
    for (int k = 1; k <= CWL + n - 1; k++) begin
      dq_in = (k >= CWL) ? 8'(base + k - CWL) : 8'($urandom);
      step();
    end
  endtask

  task automatic rd_burst(input int b, input int col, input bit bl8);
    rd_log.delete();
    set_col(0, b, col, bl8, 0); step();
    set_nop();
    repeat (CL - 2 + (bl8 ? 8 : 4)) step();
  endtask

  initial begin
    bc_exp = '{8'hA2, 8'hA3, 8'hA0, 8'hA1, 8'h30, 8'h31, 8'h32, 8'h33};
    reset_n = 0; dq_in = '0; set_nop();
    step(); step();
    chk("reset_bank_open", 32'(bank_open), 0);
    chk("reset_busy", 32'(burst_busy), 0);
    chk("reset_rd_vld", 32'(rd_vld), 0);
    chk("reset_sticky", 32'(err_sticky), 0);
    reset_n = 1;

    // BL8 write then read back
    open_bank(2, 5);
    wr_burst(2, 8, 1, 0, 8'h10);
    rd_burst(2, 8, 1);
    chk("bl8_len", 32'(rd_log.size()), 8);
    for (int i = 0; i < 8; i++) if (i < rd_log.size()) chk("bl8_data", 32'(rd_log[i]), 32'(8'h10 + i));
    chk("bl8_no_err", 32'(err_sticky), 0);

    // BC4 wrap inside a known 8-column block
    wr_burst(2, 0, 1, 0, 8'h30);
    wr_burst(2, 6, 0, 0, 8'hA0);
    rd_burst(2, 4, 1);
    chk("bc4_len", 32'(rd_log.size()), 8);
    for (int i = 0; i < 8; i++) if (i < rd_log.size()) chk("bc4_data", 32'(rd_log[i]), 32'(bc_exp[i]));

    // Protocol errors
    rd_log.delete();
    set_col(0, 3, 0, 1, 0); step();
    chk("closed_pulse", 32'(err_closed), 1);
    set_nop(); repeat (CL + 8) step();
    chk("closed_no_data", 32'(rd_log.size()), 0);
    set_act(3, 1); step();
    rd_log.delete();
    set_col(0, 3, 0, 1, 0); step();
    chk("trcd_pulse", 32'(err_trcd), 1);
    set_nop(); repeat (CL + 6) step();
    chk("trcd_data_len", 32'(rd_log.size()), 8);
    set_act(3, 2); step();
    chk("act_open_pulse", 32'(err_act_open), 1);
    set_nop(); step();
    chk("sticky_set", 32'(err_sticky), 1);

    // Overlap while an auto-precharge write is running
    rd_log.delete();
    set_col(1, 2, 16, 1, 1); dq_in = 8'($urandom); step();
    for (int k = 1; k <= CWL + 7; k++) begin
      if (k == 2) set_col(0, 2, 8, 1, 0);
      else set_nop();
      dq_in = (k >= CWL) ? 8'(8'hC0 + k - CWL) : 8'($urandom);
      step();
      if (k == 2) chk("overlap_pulse", 32'(err_overlap), 1);
      if (k == CWL + 6) chk("ap_open_before_last", 32'(bank_open[2]), 1);
    end
    chk("ap_closed_on_last", 32'(bank_open[2]), 0);
    set_nop(); repeat (CL + 8) step();
    chk("overlap_rd_dropped", 32'(rd_log.size()), 0);

    // Precharge all
    set_act(0, 0); step(); set_act(1, 1); step();
    set_act(4, 2); step(); set_act(5, 3); step();
    set_nop(); step();
    chk("four_open", 32'({bank_open[5], bank_open[4], bank_open[1], bank_open[0]}), 4'hF);
    set_pre(0, 1); step();
    chk("pre_all", 32'(bank_open), 0);
    set_col(0, 0, 0, 1, 0); step();
    chk("pre_all_rd_closed", 32'(err_closed), 1);
    set_nop(); repeat (CL + 8) step();

    // Reset in the middle of a read
    open_bank(6, 9);
    wr_burst(6, 0, 1, 0, 8'h50);
    set_col(0, 6, 0, 1, 0); step();
    set_nop(); repeat (CL + 2) step();
    chk("beat3_vld", 32'(rd_vld), 1);
    chk("beat3_data", 32'(rd_dq), 8'h53);
    reset_n = 0; step();
    chk("rst_rd_vld", 32'(rd_vld), 0);
    chk("rst_busy", 32'(burst_busy), 0);
    reset_n = 1;
    open_bank(6, 9);
    rd_burst(6, 0, 1);
    chk("rst_keep_len", 32'(rd_log.size()), 8);
    for (int i = 0; i < 8; i++) if (i < rd_log.size()) chk("rst_keep_data", 32'(rd_log[i]), 32'(8'h50 + i));

    // Random command traffic
    for (int n = 0; n < 1500; n++) begin
      rnd_r = int'($urandom_range(99));
      rnd_b = int'($urandom_range(7));
      reset_n = ($urandom_range(199) != 0);
      dq_in = 8'($urandom);
      if (rnd_r < 40) set_nop();
      else if (rnd_r < 58) begin
        if (m_busy && mb_ap && rnd_b == mb_bank) set_nop();
        else set_act(rnd_b, int'($urandom_range(3)));
      end
      else if (rnd_r < 66) set_pre(rnd_b, $urandom_range(3) == 0);
      else set_col(1'($urandom_range(1)), rnd_b, int'($urandom_range(15)),
                   1'($urandom_range(1)), $urandom_range(3) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
